elevator_car_ctrl: RTL and testbench
====================================

Name: elevator_car_ctrl

Overview:
- Car motion controller directly downstream of the direction-decision logic.
- Consumes `turn_up`/`turn_down` and a "request pending at this floor" flag.
- Sequences the car through timed floor-to-floor travel and door-open dwell.
- Owns and produces the `story` floor register (1..3) that the direction logic and request latches read back.

Parameters:
- TRAVEL_TICKS, 50000000, clock cycles to travel one floor (1 s at 50 MHz)
- DOOR_TICKS, 100000000, clock cycles the door stays open (2 s at 50 MHz)
- CNT_W, 27, timer width; must hold max(TRAVEL_TICKS, DOOR_TICKS)-1

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- turn_up  input  1  direction logic requests upward travel
- turn_down  input  1  direction logic requests downward travel
- floor_hit  input  1  active-high; a request (in-car or hall) is pending for current story
- story  output  3  current floor, binary 1..3
- moving_up  output  1  high while travelling up
- moving_down  output  1  high while travelling down
- door_open  output  1  high while door dwell active
- served  output  1  one-cycle pulse: clear requests latched for current story

Behaviour:
- Reset
  - Asynchronous, active-low. While rst_n=0: story=1, moving_up=0, moving_down=0, door_open=0, served=0, timer=0, state=IDLE.
  - Reset mid-travel or mid-dwell returns the car to floor 1; there is no position sensor.
- State machine: IDLE, UP, DOWN, ARRIVE, DOOR. All outputs are registered.
- IDLE. Priority order:
  - floor_hit=1 -> DOOR, with served pulsed.
  - else turn_up=1 and story<3 -> UP.
  - else turn_down=1 and story>1 -> DOWN.
  - else stay.
  - If turn_up and turn_down are both 1, up wins.
  - Requests that would move past floor 1 or floor 3 are ignored.
- UP / DOWN
  - moving_up (moving_down) is asserted on the first cycle in the state.
  - Timer counts 0..TRAVEL_TICKS-1. On the cycle the timer equals TRAVEL_TICKS-1: story increments (decrements), timer clears, state -> ARRIVE.
  - Inputs are ignored while travelling.
- ARRIVE: one-cycle decision state; moving_up/moving_down stay asserted. Priority order:
  - floor_hit=1 -> DOOR, with served pulsed.
  - else the same direction is still requested and the car is not at the end floor -> back to UP/DOWN; timer starts from 0.
  - else IDLE.
  - At story=3 after UP, or story=1 after DOWN, the car never continues.
- DOOR
  - served is high on the first DOOR cycle only. door_open=1 for the whole state; moving_* =0.
  - Timer counts 0..DOOR_TICKS-1, then -> IDLE with door_open=0.
  - floor_hit=1 during DOOR (re-press at the same floor) clears the timer, extending the dwell, and pulses served again.
- Latency
  - IDLE to moving_*=1: 1 cycle.
  - One-floor hop: TRAVEL_TICKS cycles to the story change, +1 cycle ARRIVE, +1 cycle to door_open.
- Width rules
  - story is never written outside 1..3.
  - Timer never exceeds its limit.
  - moving_up, moving_down and door_open are mutually exclusive at all times.

Optional Feature:
- Macro: ELEVATOR_DOOR_HOLD_EN.
- When defined:
  - Adds input port `door_hold_n` (1 bit, active-low panel button).
  - While door_hold_n=0 in DOOR, the timer is held at 0 and the door stays open indefinitely.
  - On release, the full DOOR_TICKS dwell restarts.
  - door_hold_n has no effect in any other state.
- When undefined: the port is absent and door dwell is fixed at DOOR_TICKS, extendable only by floor_hit.

Test Plan:
- Bench runs with TRAVEL_TICKS=4, DOOR_TICKS=3.
- Reset: assert rst_n=0 asynchronously mid-cycle -> story=1, all other outputs 0 immediately; release -> IDLE, outputs unchanged.
- One-hop stop:
  - Stimulus: story=1, turn_up=1, floor_hit=0; raise floor_hit when story=2.
  - Response: moving_up=1 one cycle later; story=2 after 4 cycles; ARRIVE sees floor_hit -> served pulse 1 cycle, door_open=1 for 3 cycles; then IDLE.
- Pass-through:
  - Stimulus: story=1, turn_up held, floor_hit=0.
  - Response: story=2 at cycle 5 and story=3 at cycle 10; moving_up continuous.
  - At story=3 with floor_hit=0 -> IDLE, moving_up=0, even though turn_up is still 1.
- Conflict/bounds:
  - story=2, turn_up=turn_down=1 -> UP.
  - story=1, turn_down=1 only -> stays IDLE.
  - story=3, turn_up=1 only -> stays IDLE.
- Door re-press: in DOOR, pulse floor_hit on dwell cycle 2 -> served pulses again, door_open stays high 3 more cycles (5 total).
- Reset mid-travel: story=2, in UP with timer=2, pulse rst_n low -> story=1, moving_up=0 immediately; no served pulse.

Source files
------------

// File: rtl/elevator_car_ctrl.sv
// Car motion sequencer: timed floor-to-floor travel, arrival decision and door dwell; owns the story register.
// Optional build macro ELEVATOR_DOOR_HOLD_EN adds the active-low door_hold_n panel input.
module elevator_car_ctrl #(
    parameter int TRAVEL_TICKS = 50000000,
    parameter int DOOR_TICKS   = 100000000,
    parameter int CNT_W        = 27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       turn_up,
    input  logic       turn_down,
    input  logic       floor_hit,
`ifdef ELEVATOR_DOOR_HOLD_EN
    input  logic       door_hold_n,
`endif
    output logic [2:0] story,
    output logic       moving_up,
    output logic       moving_down,
    output logic       door_open,
    output logic       served,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UP     = 3'd1,
        DOWN   = 3'd2,
        ARRIVE = 3'd3,
        DOOR   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_TICKS - 1);
    localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_TICKS - 1);

    state_t           state;
    logic [CNT_W-1:0] timer;
    logic             hold;

`ifdef ELEVATOR_DOOR_HOLD_EN
    assign hold = ~door_hold_n;
`else
    assign hold = 1'b0;
`endif

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            timer       <= '0;
            story       <= 3'd1;
            moving_up   <= 1'b0;
            moving_down <= 1'b0;
            door_open   <= 1'b0;
            served      <= 1'b0;
        end else begin
            served <= 1'b0;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (floor_hit) begin
                        state     <= DOOR;
                        door_open <= 1'b1;
                        served    <= 1'b1;
                    end else if (turn_up && story < 3'd3) begin
                        state     <= UP;
                        moving_up <= 1'b1;
                    end else if (turn_down && story > 3'd1) begin
                        state       <= DOWN;
                        moving_down <= 1'b1;
                    end
                end
                UP, DOWN: begin
                    if (timer == TRAVEL_LAST) begin
                        timer <= '0;
                        state <= ARRIVE;
                        story <= (state == UP) ? story + 3'd1 : story - 3'd1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ARRIVE: begin
                    // moving_up still records the direction just travelled.
                    timer <= '0;
                    if (floor_hit) begin
                        state       <= DOOR;
                        door_open   <= 1'b1;
                        served      <= 1'b1;
                        moving_up   <= 1'b0;
                        moving_down <= 1'b0;
                    end else if (moving_up && turn_up && story < 3'd3) begin
                        state <= UP;
                    end else if (moving_down && turn_down && story > 3'd1) begin
                        state <= DOWN;
                    end else begin
                        state       <= IDLE;
                        moving_up   <= 1'b0;
                        moving_down <= 1'b0;
                    end
                end
                DOOR: begin
                    // A re-press or a held door button restarts the full dwell.
                    if (floor_hit) begin
                        timer  <= '0;
                        served <= 1'b1;
                    end else if (hold) begin
                        timer <= '0;
                    end else if (timer == DOOR_LAST) begin
                        timer     <= '0;
                        state     <= IDLE;
                        door_open <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    timer       <= '0;
                    moving_up   <= 1'b0;
                    moving_down <= 1'b0;
                    door_open   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Directed bench for elevator_car_ctrl with TRAVEL_TICKS=4, DOOR_TICKS=3.
// Inputs change 1 ns after each rising edge; outputs are checked at that same point.
module tb_elevator_car_ctrl;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_UP     = 3'd1;
    localparam logic [2:0] S_DOWN   = 3'd2;
    localparam logic [2:0] S_ARRIVE = 3'd3;
    localparam logic [2:0] S_DOOR   = 3'd4;

    logic       clk;
    logic       rst_n;
    logic       turn_up;
    logic       turn_down;
    logic       floor_hit;
`ifdef ELEVATOR_DOOR_HOLD_EN
    logic       door_hold_n;
`endif
    logic [2:0] story;
    logic       moving_up;
    logic       moving_down;
    logic       door_open;
    logic       served;
    logic [2:0] state_dbg;

    int n_cmp;
    int n_err;
    logic [2:0] exp_q[$];

    elevator_car_ctrl #(
        .TRAVEL_TICKS(4),
        .DOOR_TICKS  (3),
        .CNT_W       (27)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .turn_up    (turn_up),
        .turn_down  (turn_down),
        .floor_hit  (floor_hit),
`ifdef ELEVATOR_DOOR_HOLD_EN
        .door_hold_n(door_hold_n),
`endif
        .story      (story),
        .moving_up  (moving_up),
        .moving_down(moving_down),
        .door_open  (door_open),
        .served     (served),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [2:0] e_story, input logic e_up,
                             input logic e_dn, input logic e_door, input logic e_srv);
        check({tag, ".story"},       story,       e_story);
        check({tag, ".moving_up"},   moving_up,   e_up);
        check({tag, ".moving_down"}, moving_down, e_dn);
        check({tag, ".door_open"},   door_open,   e_door);
        check({tag, ".served"},      served,      e_srv);
    endtask

    task automatic drive(input logic up, input logic dn, input logic hit);
        turn_up   = up;
        turn_down = dn;
        floor_hit = hit;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
`ifdef ELEVATOR_DOOR_HOLD_EN
        door_hold_n = 1'b1;
`endif
        drive(0, 0, 0);

        // reset asserted asynchronously mid-cycle
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        check_out("reset_async", 3'd1, 0, 0, 0, 0);
        check("reset_async.state", state_dbg, S_IDLE);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_out("reset_release", 3'd1, 0, 0, 0, 0);
        check("reset_release.state", state_dbg, S_IDLE);

        // one-hop stop at floor 2
        drive(1, 0, 0);
        tick();
        check_out("hop_start", 3'd1, 1, 0, 0, 0);
        drive(0, 0, 0);
        tick(); tick(); tick();
        check_out("hop_e3", 3'd1, 1, 0, 0, 0);
        tick();
        check_out("hop_arrive", 3'd2, 1, 0, 0, 0);
        check("hop_arrive.state", state_dbg, S_ARRIVE);
        drive(0, 0, 1);
        tick();
        check_out("hop_door1", 3'd2, 0, 0, 1, 1);
        drive(0, 0, 0);
        tick();
        check_out("hop_door2", 3'd2, 0, 0, 1, 0);
        tick();
        check_out("hop_door3", 3'd2, 0, 0, 1, 0);
        tick();
        check_out("hop_close", 3'd2, 0, 0, 0, 0);
        check("hop_close.state", state_dbg, S_IDLE);

        // conflicting requests at floor 2: up wins
        drive(1, 1, 0);
        tick();
        check_out("conflict", 3'd2, 1, 0, 0, 0);
        check("conflict.state", state_dbg, S_UP);
        drive(0, 0, 0);
        tick(); tick(); tick(); tick();
        check_out("to3_arrive", 3'd3, 1, 0, 0, 0);
        tick();
        check_out("to3_idle", 3'd3, 0, 0, 0, 0);

        // up request at top floor ignored
        drive(1, 0, 0);
        tick();
        check_out("top_bound", 3'd3, 0, 0, 0, 0);
        check("top_bound.state", state_dbg, S_IDLE);
        tick();
        check("top_bound2.state", state_dbg, S_IDLE);

        // downward pass-through 3 -> 1 with turn_down held
        drive(0, 1, 0);
        tick();
        check_out("down_start", 3'd3, 0, 1, 0, 0);
        tick(); tick(); tick(); tick();
        check_out("down_f2", 3'd2, 0, 1, 0, 0);
        tick();
        check("down_continue.state", state_dbg, S_DOWN);
        check_out("down_continue", 3'd2, 0, 1, 0, 0);
        tick(); tick(); tick(); tick();
        check_out("down_f1", 3'd1, 0, 1, 0, 0);
        tick();
        check_out("down_end", 3'd1, 0, 0, 0, 0);
        check("down_end.state", state_dbg, S_IDLE);

        // down request at bottom floor ignored
        tick();
        check_out("bottom_bound", 3'd1, 0, 0, 0, 0);
        check("bottom_bound.state", state_dbg, S_IDLE);

        // upward pass-through 1 -> 3 with turn_up held
        drive(1, 0, 0);
        for (int k = 0; k < 10; k++) exp_q.push_back(k < 4 ? 3'd1 : (k < 9 ? 3'd2 : 3'd3));
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("pass_story[%0d]", k), story, exp_q.pop_front());
            check($sformatf("pass_moving_up[%0d]", k), moving_up, 1'b1);
        end
        tick();
        check_out("pass_top", 3'd3, 0, 0, 0, 0);
        check("pass_top.state", state_dbg, S_IDLE);
        drive(0, 0, 0);

        // door re-press on dwell cycle 2
        drive(0, 0, 1);
        tick();
        check_out("repress_d0", 3'd3, 0, 0, 1, 1);
        drive(0, 0, 0);
        tick();
        check_out("repress_d1", 3'd3, 0, 0, 1, 0);
        drive(0, 0, 1);
        tick();
        check_out("repress_d2", 3'd3, 0, 0, 1, 1);
        drive(0, 0, 0);
        tick();
        check_out("repress_d3", 3'd3, 0, 0, 1, 0);
        tick();
        check_out("repress_d4", 3'd3, 0, 0, 1, 0);
        tick();
        check_out("repress_close", 3'd3, 0, 0, 0, 0);
        check("repress_close.state", state_dbg, S_IDLE);

        // move to floor 2, then reset mid-travel with timer=2
        drive(0, 1, 0);
        tick();
        drive(0, 0, 0);
        tick(); tick(); tick(); tick();
        tick();
        check_out("mid_setup", 3'd2, 0, 0, 0, 0);
        drive(1, 0, 0);
        tick();
        drive(0, 0, 0);
        tick(); tick();
        check_out("mid_travel", 3'd2, 1, 0, 0, 0);
        #3 rst_n = 1'b0;
        #1;
        check_out("mid_reset", 3'd1, 0, 0, 0, 0);
        check("mid_reset.state", state_dbg, S_IDLE);
        tick();
        rst_n = 1'b1;
        tick();
        check_out("mid_release", 3'd1, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
